pipe_stage_reg: RTL and testbench

Parametrised, multi-stage successor to the fixed inter-stage pipeline registers (ID/EX, EX/M, M/WB) of the pipelined CPU. It carries a control bundle and a data bundle through DEPTH register stages, each with its own valid bit. It adds a valid/ready elastic handshake, a stall that freezes every stage, a flush that kills every stage, and NOP-bubble insertion (control forced to zero). It sits between any two CPU pipeline stages.

---
 rtl/pipe_stage_reg.sv | 136 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Elastic multi-stage pipeline register: DEPTH stages of {valid, ctrl, data}
// with stall, flush, bubble insertion and compaction. State moves on the falling clock edge.

module pipe_stage_reg_stage #(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              adv,
    input  logic              ld_v,
    input  logic [CTRL_W-1:0] ld_ctrl,
    input  logic [DATA_W-1:0] ld_data,
    output logic              v,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data,
    output logic              v_nxt
);
    logic [CTRL_W-1:0] ctrl_nxt;
    logic [DATA_W-1:0] data_nxt;

    // Bubbles and flushes zero the control bundle but leave data untouched.
    always_comb begin
        v_nxt    = v;
        ctrl_nxt = ctrl;
        data_nxt = data;
        if (flush) begin
            v_nxt    = 1'b0;
            ctrl_nxt = '0;
        end else if (adv) begin
            if (ld_v) begin
                v_nxt    = 1'b1;
                ctrl_nxt = ld_ctrl;
                data_nxt = ld_data;
            end else begin
                v_nxt    = 1'b0;
                ctrl_nxt = '0;
            end
        end
    end

    always_ff @(negedge clk) begin
        if (!rst) begin
            v    <= 1'b0;
            ctrl <= '0;
            data <= '0;
        end else begin
            v    <= v_nxt;
            ctrl <= ctrl_nxt;
            data <= data_nxt;
        end
    end
endmodule

module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  occupancy
);
    logic [DEPTH-1:0]             v, v_nxt, adv, ld_v;
    logic [DEPTH-1:0][CTRL_W-1:0] ctrl, ld_ctrl;
    logic [DEPTH-1:0][DATA_W-1:0] data, ld_data;
    logic                         in_fire;
    logic [CNT_W-1:0]             cnt_nxt;

    // Ready chain: a stage may move if it is empty or the stage after it moves,
    // which lets bubbles collapse while the output is blocked.
    always_comb begin
        adv[DEPTH-1] = !stall & (!v[DEPTH-1] | out_ready);
        for (int i = DEPTH - 2; i >= 0; i--)
            adv[i] = !stall & (!v[i] | adv[i+1]);
    end

    assign in_ready = adv[0] & !flush & rst;
    assign in_fire  = in_valid & in_ready;

    always_comb begin
        ld_v[0]    = in_fire;
        ld_ctrl[0] = in_ctrl;
        ld_data[0] = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            ld_v[i]    = v[i-1];
            ld_ctrl[i] = ctrl[i-1];
            ld_data[i] = data[i-1];
        end
    end

    generate
        for (genvar g = 0; g < DEPTH; g++) begin : g_stage
            pipe_stage_reg_stage #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_stage (
                .clk     (clk),
                .rst     (rst),
                .flush   (flush),
                .adv     (adv[g]),
                .ld_v    (ld_v[g]),
                .ld_ctrl (ld_ctrl[g]),
                .ld_data (ld_data[g]),
                .v       (v[g]),
                .ctrl    (ctrl[g]),
                .data    (data[g]),
                .v_nxt   (v_nxt[g])
            );
        end
    endgenerate

    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < DEPTH; i++)
            cnt_nxt = cnt_nxt + CNT_W'(v_nxt[i]);
    end

    always_ff @(negedge clk) begin
        if (!rst) occupancy <= '0;
        else      occupancy <= cnt_nxt;
    end

    assign out_valid = v[DEPTH-1];
    assign out_ctrl  = ctrl[DEPTH-1];
    assign out_data  = data[DEPTH-1];
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: scoreboard on every transfer plus directed checks
// of reset, backpressure, bubbles, stall, flush and random streaming.

module tb_pipe_stage_reg;
    localparam int DATA_W = 32;
    localparam int CTRL_W = 8;
    localparam int DEPTH  = 2;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              clk = 1'b1;
    logic              rst, stall, flush, in_valid, in_ready, out_valid, out_ready;
    logic [CTRL_W-1:0] in_ctrl, out_ctrl;
    logic [DATA_W-1:0] in_data, out_data;
    logic [CNT_W-1:0]  occupancy;

    int n_cmp = 0;
    int n_err = 0;
    logic [CTRL_W+DATA_W-1:0] sb_q[$];

    pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Scoreboard: sees pre-edge values at the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready && !stall) begin
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected_out", {32'd0, out_data}, 64'hDEAD);
                end else begin
                    chk("sb_out", {24'd0, out_ctrl, out_data}, {24'd0, sb_q.pop_front()});
                end
            end
            if (flush) sb_q.delete();
            else if (in_valid && in_ready) sb_q.push_back({in_ctrl, in_data});
        end
    end

    task automatic edge_wait();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic vld, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d);
        in_valid = vld;
        in_ctrl  = c;
        in_data  = d;
        #1;
    endtask

    initial begin
        rst = 1'b0; stall = 1'b0; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, '0, '0);
        edge_wait();
        edge_wait();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_ctrl", 64'(out_ctrl), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);

        // Streaming
        rst = 1'b1; out_ready = 1'b1;
        drive(1'b1, 8'h01, 32'h11);
        chk("str_in_ready", 64'(in_ready), 64'd1);
        edge_wait();
        chk("str_lat_e1_valid", 64'(out_valid), 64'd0);
        chk("str_occ_e1", 64'(occupancy), 64'd1);
        drive(1'b1, 8'h02, 32'h22);
        edge_wait();
        chk("str_lat_e2_valid", 64'(out_valid), 64'd1);
        chk("str_data0", 64'(out_data), 64'h11);
        chk("str_occ_e2", 64'(occupancy), 64'd2);
        drive(1'b1, 8'h03, 32'h33);
        edge_wait();
        chk("str_data1", 64'(out_data), 64'h22);
        drive(1'b0, '0, '0);
        edge_wait();
        chk("str_data2", 64'(out_data), 64'h33);
        edge_wait();
        chk("str_empty", 64'(occupancy), 64'd0);

        // Backpressure fill and drain
        out_ready = 1'b0;
        drive(1'b1, 8'h01, 32'h11);
        edge_wait();
        drive(1'b1, 8'h02, 32'h22);
        chk("bp_in_ready2", 64'(in_ready), 64'd1);
        edge_wait();
        drive(1'b1, 8'h03, 32'h33);
        chk("bp_in_ready3", 64'(in_ready), 64'd0);
        edge_wait();
        chk("bp_occ", 64'(occupancy), 64'd2);
        chk("bp_hold", 64'(out_data), 64'h11);
        out_ready = 1'b1;
        #1;
        chk("bp_in_ready_rel", 64'(in_ready), 64'd1);
        edge_wait();
        chk("bp_drain0", 64'(out_data), 64'h22);
        drive(1'b0, '0, '0);
        edge_wait();
        chk("bp_drain1", 64'(out_data), 64'h33);
        edge_wait();
        chk("bp_empty", 64'(occupancy), 64'd0);

        // Bubble insertion
        drive(1'b1, 8'hFF, 32'hAA);
        edge_wait();
        drive(1'b0, 8'hFF, 32'hBB);
        edge_wait();
        chk("bub_v0", 64'(out_valid), 64'd1);
        chk("bub_c0", 64'(out_ctrl), 64'hFF);
        drive(1'b1, 8'hFF, 32'hCC);
        edge_wait();
        chk("bub_v1", 64'(out_valid), 64'd0);
        chk("bub_c1", 64'(out_ctrl), 64'h00);
        drive(1'b0, '0, '0);
        edge_wait();
        chk("bub_v2", 64'(out_valid), 64'd1);
        chk("bub_d2", 64'(out_data), 64'hCC);
        edge_wait();

        // Stall on a full pipe
        drive(1'b1, 8'h04, 32'h41);
        edge_wait();
        drive(1'b1, 8'h04, 32'h42);
        edge_wait();
        stall = 1'b1;
        drive(1'b1, 8'h04, 32'h43);
        chk("stl_in_ready", 64'(in_ready), 64'd0);
        for (int k = 0; k < 3; k++) begin
            edge_wait();
            chk("stl_data", 64'(out_data), 64'h41);
            chk("stl_occ", 64'(occupancy), 64'd2);
            chk("stl_valid", 64'(out_valid), 64'd1);
        end
        stall = 1'b0;
        #1;
        edge_wait();
        chk("stl_resume", 64'(out_data), 64'h42);
        drive(1'b0, '0, '0);
        edge_wait();
        chk("stl_resume2", 64'(out_data), 64'h43);
        edge_wait();

        // Flush beats stall
        out_ready = 1'b0;
        drive(1'b1, 8'h05, 32'h51);
        edge_wait();
        drive(1'b1, 8'h05, 32'h52);
        edge_wait();
        stall = 1'b1; flush = 1'b1;
        drive(1'b1, 8'h05, 32'h53);
        chk("fl_in_ready", 64'(in_ready), 64'd0);
        edge_wait();
        chk("fl_occ", 64'(occupancy), 64'd0);
        chk("fl_valid", 64'(out_valid), 64'd0);
        chk("fl_ctrl", 64'(out_ctrl), 64'd0);
        stall = 1'b0; flush = 1'b0; out_ready = 1'b1;
        drive(1'b0, '0, '0);
        edge_wait();
        chk("fl_not_captured", 64'(out_valid), 64'd0);
        chk("fl_occ2", 64'(occupancy), 64'd0);

        // Reset mid-operation
        out_ready = 1'b0;
        drive(1'b1, 8'h06, 32'h61);
        edge_wait();
        drive(1'b1, 8'h06, 32'h62);
        edge_wait();
        chk("mr_occ", 64'(occupancy), 64'd2);
        rst = 1'b0;
        drive(1'b0, '0, '0);
        chk("mr_in_ready", 64'(in_ready), 64'd0);
        edge_wait();
        chk("mr_valid", 64'(out_valid), 64'd0);
        chk("mr_ctrl", 64'(out_ctrl), 64'd0);
        chk("mr_data", 64'(out_data), 64'd0);
        chk("mr_occ0", 64'(occupancy), 64'd0);
        rst = 1'b1; out_ready = 1'b1;
        drive(1'b1, 8'h07, 32'h71);
        edge_wait();
        chk("mr_lat1", 64'(out_valid), 64'd0);
        drive(1'b0, '0, '0);
        edge_wait();
        chk("mr_lat2", 64'(out_valid), 64'd1);
        chk("mr_data2", 64'(out_data), 64'h71);
        edge_wait();

        // Random streaming with backpressure; scoreboard checks order
        for (int k = 0; k < 300; k++) begin
            out_ready = 1'($urandom_range(0, 3) != 0);
            stall     = 1'($urandom_range(0, 9) == 0);
            drive(1'($urandom_range(0, 1)), 8'($urandom), $urandom);
            edge_wait();
            if (occupancy > 2'd2) chk("rnd_occ_range", 64'(occupancy), 64'd2);
        end

        // Drain with a bounded wait
        stall = 1'b0; out_ready = 1'b1;
        drive(1'b0, '0, '0);
        for (int k = 0; k < 10 && occupancy != 0; k++) edge_wait();
        chk("drain_occ", 64'(occupancy), 64'd0);
        chk("drain_sb_empty", 64'(sb_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
